line_rasterizer: RTL and testbench

Parametrised Bresenham line engine for the graphics pipeline. It replaces the fixed 10/9-bit line plotter.
- Accepts a line command (endpoints plus colour) through a start/busy handshake.
- Emits one pixel per accepted beat on a valid/ready stream with backpressure.
- Sits between the graphics command decoder and the frame-buffer write arbiter.

---
 rtl/line_rasterizer_if.sv | 32 +++
 rtl/line_rasterizer.sv | 147 ++++++++++++++
 tb/tb_line_rasterizer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_rasterizer_if.sv
// Command and pixel-stream bundle for line_rasterizer. Master is the command decoder /
// frame-buffer side, slave is the rasterizer itself.
interface line_rasterizer_if #(
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned Y_WIDTH     = 9,
  parameter int unsigned COLOR_WIDTH = 4
);
  logic                   start_in;
  logic                   abort_in;
  logic [X_WIDTH-1:0]     x0_in;
  logic [Y_WIDTH-1:0]     y0_in;
  logic [X_WIDTH-1:0]     x1_in;
  logic [Y_WIDTH-1:0]     y1_in;
  logic [COLOR_WIDTH-1:0] color_in;
  logic                   busy_out;
  logic                   done_out;
  logic [X_WIDTH-1:0]     pixel_x_out;
  logic [Y_WIDTH-1:0]     pixel_y_out;
  logic [COLOR_WIDTH-1:0] pixel_color_out;
  logic                   pixel_valid_out;
  logic                   pixel_ready_in;

  modport master (
    output start_in, abort_in, x0_in, y0_in, x1_in, y1_in, color_in, pixel_ready_in,
    input  busy_out, done_out, pixel_x_out, pixel_y_out, pixel_color_out, pixel_valid_out
  );

  modport slave (
    input  start_in, abort_in, x0_in, y0_in, x1_in, y1_in, color_in, pixel_ready_in,
    output busy_out, done_out, pixel_x_out, pixel_y_out, pixel_color_out, pixel_valid_out
  );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line engine: one command in, one pixel per valid/ready beat out.
// Define LINE_CLIP_EN to suppress points outside SCREEN_W x SCREEN_H.
module line_rasterizer #(
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned Y_WIDTH     = 9,
  parameter int unsigned COLOR_WIDTH = 4,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 400
) (
  input logic              clock_in,
  input logic              reset_n_in,
  line_rasterizer_if.slave bus
);
  localparam int unsigned CW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e                 state_q, state_d;
  logic [X_WIDTH-1:0]     x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
  logic [Y_WIDTH-1:0]     y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic signed [CW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                   sx_q, sx_d, sy_q, sy_d, done_q, done_d;

  logic [X_WIDTH-1:0]     x_abs;
  logic [Y_WIDTH-1:0]     y_abs;
  logic signed [CW:0]     e2, dx_ext, dy_ext;
  logic                   step_x, step_y, at_end, visible, advance;

`ifdef LINE_CLIP_EN
  assign visible = (32'(cur_x_q) < SCREEN_W) && (32'(cur_y_q) < SCREEN_H);
`else
  logic unused_screen;
  assign unused_screen = ^{SCREEN_W, SCREEN_H};
  assign visible       = 1'b1;
`endif

  always_comb begin
    x_abs   = (x1_q > x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    y_abs   = (y1_q > y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    e2      = {err_q, 1'b0};
    dx_ext  = {dx_q[CW-1], dx_q};
    dy_ext  = {dy_q[CW-1], dy_q};
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    at_end  = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    // Hidden points step on their own; visible ones wait for the downstream handshake.
    advance = (state_q == StDraw) && (visible ? bus.pixel_ready_in : 1'b1);
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    done_d  = 1'b0;
    if (bus.abort_in) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_in) begin
            x0_d    = bus.x0_in;
            y0_d    = bus.y0_in;
            x1_d    = bus.x1_in;
            y1_d    = bus.y1_in;
            color_d = bus.color_in;
            state_d = StSetup;
          end
        end
        StSetup: begin
          dx_d    = signed'(CW'(x_abs));
          dy_d    = -signed'(CW'(y_abs));
          err_d   = signed'(CW'(x_abs)) - signed'(CW'(y_abs));
          sx_d    = (x1_q > x0_q);
          sy_d    = (y1_q > y0_q);
          cur_x_d = x0_q;
          cur_y_d = y0_q;
          state_d = StDraw;
        end
        StDraw: begin
          if (advance) begin
            if (at_end) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
              if (step_x) cur_x_d = sx_q ? (cur_x_q + X_WIDTH'(1)) : (cur_x_q - X_WIDTH'(1));
              if (step_y) cur_y_d = sy_q ? (cur_y_q + Y_WIDTH'(1)) : (cur_y_q - Y_WIDTH'(1));
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_out        = (state_q != StIdle);
  assign bus.done_out        = done_q;
  assign bus.pixel_valid_out = (state_q == StDraw) && visible;
  assign bus.pixel_x_out     = cur_x_q;
  assign bus.pixel_y_out     = cur_y_q;
  assign bus.pixel_color_out = color_q;
endmodule

// File: tb/tb_line_rasterizer.sv
// Randomised bench for line_rasterizer: a point-list model of each line is walked by a
// single negedge compare process; a few literal expectations pin the model and timing.
module tb_line_rasterizer;
  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned CWD = 4;
  localparam int unsigned SW  = 640;
  localparam int unsigned SH  = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  line_rasterizer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CWD)) bus ();

  line_rasterizer #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CWD), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clock_in  (clk),
    .reset_n_in(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; bit vis;} pt_t;
  pt_t gen_q[$];
  pt_t exp_q[$];
  int  phase     = 0;  // 0 idle, 1 setup, 2 drawing
  bit  done_exp  = 1'b0;
  int  exp_color = 0;
  int  acc_cnt   = 0;
  int  rmode     = 0;  // ready: 0 always high, 1 toggling, 2 random
  bit  prev_hold = 1'b0;
  int  prev_x, prev_y, prev_c;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference point list straight from the Bresenham rules, in plain integers.
  function automatic void gen(input int x0, input int y0, input int x1, input int y1);
    int dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    int dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
    int sx  = (x1 > x0) ? 1 : -1;
    int sy  = (y1 > y0) ? 1 : -1;
    int err = dx + dy;
    int x   = x0;
    int y   = y0;
    int e2;
    pt_t p;
    gen_q.delete();
    for (int guard = 0; guard < 5000; guard++) begin
      p.x = x;
      p.y = y;
`ifdef LINE_CLIP_EN
      p.vis = (x < int'(SW)) && (y < int'(SH));
`else
      p.vis = 1'b1;
`endif
      gen_q.push_back(p);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.pixel_ready_in = 1'b1;
      1:       bus.pixel_ready_in = ~bus.pixel_ready_in;
      default: bus.pixel_ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      phase     = 0;
      exp_q.delete();
      done_exp  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("busy", int'(bus.busy_out), (phase != 0) ? 1 : 0);
      chk("done", int'(bus.done_out), int'(done_exp));
      if (phase == 2 && exp_q.size() > 0 && exp_q[0].vis) begin
        chk("valid", int'(bus.pixel_valid_out), 1);
        chk("pixel_x", int'(bus.pixel_x_out), exp_q[0].x);
        chk("pixel_y", int'(bus.pixel_y_out), exp_q[0].y);
        chk("pixel_color", int'(bus.pixel_color_out), exp_color);
      end else begin
        chk("valid", int'(bus.pixel_valid_out), 0);
      end
      if (prev_hold) begin
        chk("hold_valid", int'(bus.pixel_valid_out), 1);
        chk("hold_x", int'(bus.pixel_x_out), prev_x);
        chk("hold_y", int'(bus.pixel_y_out), prev_y);
        chk("hold_color", int'(bus.pixel_color_out), prev_c);
      end
      prev_hold = bus.pixel_valid_out && !bus.pixel_ready_in && !bus.abort_in;
      prev_x    = int'(bus.pixel_x_out);
      prev_y    = int'(bus.pixel_y_out);
      prev_c    = int'(bus.pixel_color_out);
      done_exp  = 1'b0;
      if (bus.abort_in) begin
        phase = 0;
        exp_q.delete();
      end else begin
        case (phase)
          0: if (bus.start_in) begin
            gen(int'(bus.x0_in), int'(bus.y0_in), int'(bus.x1_in), int'(bus.y1_in));
            exp_q     = gen_q;
            exp_color = int'(bus.color_in);
            phase     = 1;
          end
          1: phase = 2;
          default: begin
            if (exp_q.size() == 0) begin
              phase = 0;
            end else if (!exp_q[0].vis || bus.pixel_ready_in) begin
              if (exp_q[0].vis) acc_cnt++;
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) begin
                phase    = 0;
                done_exp = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    bus.x0_in    = XW'(x0);
    bus.y0_in    = YW'(y0);
    bus.x1_in    = XW'(x1);
    bus.y1_in    = YW'(y1);
    bus.color_in = CWD'(c);
    bus.start_in = 1'b1;
  endtask

  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int c, input int mode);
    rmode = mode;
    @(posedge clk); #1;
    set_cmd(x0, y0, x1, y1, c);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((bus.busy_out || phase != 0) && n < budget);
    chk(nm, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_busy"}, int'(bus.busy_out), 0);
    chk({nm, "_done"}, int'(bus.done_out), 0);
    chk({nm, "_valid"}, int'(bus.pixel_valid_out), 0);
    chk({nm, "_x"}, int'(bus.pixel_x_out), 0);
    chk({nm, "_y"}, int'(bus.pixel_y_out), 0);
    chk({nm, "_color"}, int'(bus.pixel_color_out), 0);
  endtask

  int diag_x[4]  = '{10, 9, 8, 7};
  int diag_y[4]  = '{10, 11, 12, 13};
  int steep_x[6] = '{0, 0, 1, 1, 2, 2};
  int steep_y[6] = '{0, 1, 2, 3, 4, 5};

  initial begin
    int base, n, x0, y0, x1, y1;
    bus.start_in       = 1'b0;
    bus.abort_in       = 1'b0;
    bus.x0_in          = '0;
    bus.y0_in          = '0;
    bus.x1_in          = '0;
    bus.y1_in          = '0;
    bus.color_in       = '0;
    bus.pixel_ready_in = 1'b1;

    #12;
    chk_outputs_zero("reset");
    @(negedge clk); #2;
    rst_n = 1'b1;

    gen(10, 10, 7, 13);
    chk("model_diag_len", gen_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("model_diag_x", gen_q[i].x, diag_x[i]);
      chk("model_diag_y", gen_q[i].y, diag_y[i]);
    end
    gen(0, 0, 2, 5);
    chk("model_steep_len", gen_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("model_steep_x", gen_q[i].x, steep_x[i]);
      chk("model_steep_y", gen_q[i].y, steep_y[i]);
    end
    gen(0, 0, 1023, 511);
    chk("model_long_len", gen_q.size(), 1024);
    gen(3, 3, 3, 3);
    chk("model_point_len", gen_q.size(), 1);

    // Horizontal line with literal cycle-by-cycle timing.
    rmode = 0;
    @(posedge clk); #1;
    set_cmd(2, 5, 6, 5, 3);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("horiz_setup_busy", int'(bus.busy_out), 1);
        chk("horiz_setup_valid", int'(bus.pixel_valid_out), 0);
      end else if (k <= 6) begin
        chk("horiz_valid", int'(bus.pixel_valid_out), 1);
        chk("horiz_x", int'(bus.pixel_x_out), k);
        chk("horiz_y", int'(bus.pixel_y_out), 5);
      end else begin
        chk("horiz_done", int'(bus.done_out), 1);
        chk("horiz_busy_low", int'(bus.busy_out), 0);
        chk("horiz_valid_low", int'(bus.pixel_valid_out), 0);
      end
    end
    wait_idle("horiz_idle", 20);

    run_line(10, 10, 7, 13, 'hA, 0);
    wait_idle("diag_idle", 50);

    // Steep line with toggling ready and an ignored mid-line start.
    base = acc_cnt;
    run_line(0, 0, 2, 5, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    set_cmd(50, 50, 60, 60, 5);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    wait_idle("steep_idle", 60);
    chk("steep_count", acc_cnt - base, 6);

    run_line(3, 3, 3, 3, 7, 0);
    wait_idle("point_idle", 20);

    // Abort after the fourth pixel, then start immediately.
    base = acc_cnt;
    run_line(0, 0, 100, 0, 2, 0);
    n = 0;
    while (acc_cnt < base + 4 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reach", (n < 100) ? 1 : 0, 1);
    @(posedge clk); #1;
    bus.abort_in = 1'b1;
    @(posedge clk); #1;
    bus.abort_in = 1'b0;
    set_cmd(3, 3, 5, 4, 9);
    @(negedge clk);
    chk("abort_valid", int'(bus.pixel_valid_out), 0);
    chk("abort_done", int'(bus.done_out), 0);
    chk("abort_busy", int'(bus.busy_out), 0);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(negedge clk);
    chk("restart_busy", int'(bus.busy_out), 1);
    wait_idle("restart_idle", 30);
    chk("abort_count", acc_cnt - base, 4 + 3);

    base = acc_cnt;
    run_line(637, 0, 642, 0, 4, 0);
    wait_idle("clip_idle", 30);
`ifdef LINE_CLIP_EN
    chk("clip_count", acc_cnt - base, 3);
`else
    chk("clip_count", acc_cnt - base, 6);
`endif

    run_line(0, 0, 1023, 511, 1, 0);
    wait_idle("corner_a_idle", 2000);
    run_line(1023, 511, 0, 0, 2, 2);
    wait_idle("corner_b_idle", 5000);
    run_line(1023, 0, 1023, 511, 3, 1);
    wait_idle("edge_idle", 2000);
    run_line(0, 511, 1023, 0, 4, 0);
    wait_idle("anti_idle", 2000);

    for (int i = 0; i < 40; i++) begin
      x0 = int'($urandom_range(0, 1023));
      y0 = int'($urandom_range(0, 511));
      x1 = x0 + int'($urandom_range(0, 80)) - 40;
      y1 = y0 + int'($urandom_range(0, 80)) - 40;
      if ($urandom_range(0, 4) == 0) x1 = x0;
      if ($urandom_range(0, 4) == 0) y1 = y0;
      x1 = (x1 < 0) ? 0 : (x1 > 1023) ? 1023 : x1;
      y1 = (y1 < 0) ? 0 : (y1 > 511) ? 511 : y1;
      run_line(x0, y0, x1, y1, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      wait_idle("rand_idle", 1000);
    end

    // Asynchronous reset between clock edges mid-line.
    run_line(0, 0, 200, 100, 6, 0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_line(5, 5, 9, 2, 1, 2);
    wait_idle("post_reset_idle", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
